pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/halt controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    STALL_MEM = 3'd1,
    DRAIN     = 3'd2,
    HALTED    = 3'd3,
    STEP      = 3'd4
  } ctrlState_t;

  // Cycles needed to retire the instructions already past ID when HALT is seen.
  localparam int DRAIN_DEPTH = 3;
  localparam int DRAIN_CNT_W = $clog2(DRAIN_DEPTH + 1);
  localparam int STALL_CNT_W = 16;

  // A load in EX feeding a source of the ID instruction; $zero never creates a hazard.
  function automatic logic loadUse(
    input logic       exMemRead,
    input logic [4:0] exRt,
    input logic [4:0] idRs,
    input logic [4:0] idRt,
    input logic       idUsesRt
  );
    return exMemRead & (exRt != 5'd0) &
           ((exRt == idRs) | (idUsesRt & (exRt == idRt)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle statistic.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stall, memory-wait hold, HALT drain and debug resume/step.
// Latency: latch enables and flush are combinational; state, halted and stall_cnt are registered.
// Backpressure: mem_busy freezes every stage; optional single-step under PIPE_CTRL_STEP_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic                   ex_memread,
  input  logic [4:0]             ex_rt,
  input  logic                   mem_busy,
  input  logic                   halt_in,
  input  logic                   run_req,
  input  logic                   step_req,
  output logic                   pc_le,
  output logic                   ifid_le,
  output logic                   idex_le,
  output logic                   exmem_le,
  output logic                   memwb_le,
  output logic                   idex_flush,
  output logic [2:0]             state,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  ctrlState_t             stateQ, stateNext;
  logic [DRAIN_CNT_W-1:0] drainCntQ, drainCntNext;
  // Remembers that a memory stall began inside a single step, so it ends in HALTED.
  logic                   stallToHaltedQ, stallToHaltedNext;
  logic                   haltedQ;
  logic                   hazard;
  logic                   stepGo;
  logic                   stallInc;

  assign hazard = loadUse(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt);

`ifdef PIPE_CTRL_STEP_EN
  assign stepGo = step_req & ~run_req;
`else
  // Stepping compiled out: the port stays but can never leave HALTED.
  assign stepGo = 1'b0 & step_req;
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ         <= RUN;
      drainCntQ      <= '0;
      stallToHaltedQ <= 1'b0;
      haltedQ        <= 1'b0;
    end else begin
      stateQ         <= stateNext;
      drainCntQ      <= drainCntNext;
      stallToHaltedQ <= stallToHaltedNext;
      haltedQ        <= (stateNext == HALTED);
    end
  end

  // Next-state logic; RUN priority is mem_busy, then load-use, then halt.
  always_comb begin
    stateNext         = stateQ;
    drainCntNext      = drainCntQ;
    stallToHaltedNext = stallToHaltedQ;
    case (stateQ)
      RUN: begin
        if (mem_busy) begin
          stateNext         = STALL_MEM;
          stallToHaltedNext = 1'b0;
        end else if (hazard) begin
          stateNext = RUN;
        end else if (halt_in) begin
          stateNext    = DRAIN;
          drainCntNext = DRAIN_CNT_W'(DRAIN_DEPTH);
        end
      end
      STALL_MEM: begin
        if (!mem_busy) begin
          stateNext         = stallToHaltedQ ? HALTED : RUN;
          stallToHaltedNext = 1'b0;
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          if (drainCntQ <= DRAIN_CNT_W'(1)) begin
            stateNext    = HALTED;
            drainCntNext = '0;
          end else begin
            drainCntNext = drainCntQ - DRAIN_CNT_W'(1);
          end
        end
      end
      HALTED: begin
        if (run_req) begin
          stateNext = RUN;
        end else if (stepGo) begin
          stateNext = STEP;
        end
      end
      STEP: begin
        if (mem_busy) begin
          stateNext         = STALL_MEM;
          stallToHaltedNext = 1'b1;
        end else begin
          stateNext = HALTED;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  // Latch enables and ID/EX bubble; reset holds everything and flushes.
  always_comb begin
    pc_le      = 1'b0;
    ifid_le    = 1'b0;
    idex_le    = 1'b0;
    exmem_le   = 1'b0;
    memwb_le   = 1'b0;
    idex_flush = 1'b0;
    if (reset) begin
      idex_flush = 1'b1;
    end else begin
      case (stateQ)
        RUN: begin
          if (mem_busy) begin
            idex_flush = 1'b0;
          end else if (hazard || halt_in) begin
            // Freeze fetch, inject a bubble, let older instructions advance.
            idex_le    = 1'b1;
            exmem_le   = 1'b1;
            memwb_le   = 1'b1;
            idex_flush = 1'b1;
          end else begin
            pc_le    = 1'b1;
            ifid_le  = 1'b1;
            idex_le  = 1'b1;
            exmem_le = 1'b1;
            memwb_le = 1'b1;
          end
        end
        STALL_MEM, STEP: begin
          if (!mem_busy) begin
            pc_le    = 1'b1;
            ifid_le  = 1'b1;
            idex_le  = 1'b1;
            exmem_le = 1'b1;
            memwb_le = 1'b1;
          end
        end
        DRAIN: begin
          idex_flush = 1'b1;
          idex_le    = ~mem_busy;
          exmem_le   = ~mem_busy;
          memwb_le   = ~mem_busy;
        end
        default: begin
          idex_flush = 1'b0;
        end
      endcase
    end
  end

  // Count stalled fetch cycles while the pipeline is live.
  assign stallInc = ((stateQ == RUN) || (stateQ == STALL_MEM) || (stateQ == DRAIN)) && !pc_le;

  sat_counter #(
    .W(STALL_CNT_W)
  ) uStallCnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stallInc),
    .count(stall_cnt)
  );

  assign state  = stateQ;
  assign halted = haltedQ;

endmodule
